game_ctrl: RTL and testbench

//  Session-level initiator for the round controller: issues round_start, drives the per-level

---
 rtl/game_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_game_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: session-level controller for the whack-a-mole round block.
// Accepts the player's start, hands per-level round configuration to the
// round block, starts each round, tallies hits into a saturating score and
// decides after each round whether to advance a level, win, or end the game.
module game_ctrl #(
  parameter int          NUM_LEVELS    = 4,
  parameter logic [26:0] BASE_INTERVAL = 27'd50_000_000,
  parameter logic [26:0] BASE_DURATION = 27'd50_000_000,
  parameter int          BASE_MOLES    = 3,
  parameter int          PASS_HITS     = 2,
  parameter logic [26:0] GAP_CYCLES    = 27'd25_000_000,
  parameter int          ACK_TIMEOUT   = 15,
  parameter int          SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               round_over,
  input  logic               hit_success,
  output logic               round_start,
  output logic [26:0]        interval,
  output logic [26:0]        duration,
  output logic [2:0]         molenum,
  output logic [2:0]         level,
  output logic [SCORE_W-1:0] score,
  output logic               playing,
  output logic               game_won,
  output logic               error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_RUN,
    S_EVAL,
    S_GAP,
    S_OVER
  } state_t;

  localparam logic [2:0] LAST_LEVEL = 3'(NUM_LEVELS - 1);
  localparam logic [3:0] PASS_MIN   = 4'(PASS_HITS);
  localparam logic [7:0] ACK_MAX    = 8'(ACK_TIMEOUT);

  state_t             state;
  state_t             state_next;

  logic [2:0]         level_q;
  logic [SCORE_W-1:0] score_q;
  logic [2:0]         round_hits;
  logic               game_won_q;
  logic               error_q;
  logic               round_start_q;
  logic [7:0]         ack_cnt;
  logic [26:0]        gap_cnt;
  logic [26:0]        interval_q;
  logic [26:0]        duration_q;
  logic [2:0]         molenum_q;

  // Control strobes decoded by the next-state logic
  logic               start_game;
  logic               fire;
  logic               ack_fail;
  logic               count_hit;
  logic               advance;
  logic               win;
  logic               eval_done;
  logic               gap_done;
  logic               state_entry;

  // Score saturates at all-ones rather than wrapping
  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Per-round hit tally saturates at 7
  function automatic logic [2:0] sat_hits(input logic [2:0] v);
    return (&v) ? v : v + 3'd1;
  endfunction

  function automatic logic [26:0] cfg_interval(input logic [2:0] lvl);
    return BASE_INTERVAL >> lvl;
  endfunction

  function automatic logic [26:0] cfg_duration(input logic [2:0] lvl);
    return BASE_DURATION >> lvl;
  endfunction

  // Moles per round grow by one per level, capped at the 3-bit maximum
  function automatic logic [2:0] cfg_molenum(input logic [2:0] lvl);
    logic [3:0] m;
    m = 4'(BASE_MOLES) + {1'b0, lvl};
    return (m > 4'd7) ? 3'd7 : m[2:0];
  endfunction

  assign gap_done    = (GAP_CYCLES == 27'd0) || (gap_cnt == GAP_CYCLES - 27'd1);
  assign state_entry = (state_next != state);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and per-state control strobes
  always_comb begin
    state_next = state;
    start_game = 1'b0;
    fire       = 1'b0;
    ack_fail   = 1'b0;
    count_hit  = 1'b0;
    advance    = 1'b0;
    win        = 1'b0;
    eval_done  = 1'b0;
    case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          start_game = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Only kick the round block once it reports idle
        if (round_over) begin
          fire       = 1'b1;
          state_next = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (!round_over) begin
          state_next = S_RUN;
        end else if (ack_cnt == ACK_MAX) begin
          ack_fail   = 1'b1;
          state_next = S_OVER;
        end
      end
      S_RUN: begin
        // A hit landing in the same cycle as round_over rising still counts
        count_hit = hit_success;
        if (round_over) state_next = S_EVAL;
      end
      S_EVAL: begin
        eval_done = 1'b1;
        if ({1'b0, round_hits} >= PASS_MIN) begin
          if (level_q == LAST_LEVEL) begin
            win        = 1'b1;
            state_next = S_OVER;
          end else begin
            advance    = 1'b1;
            state_next = S_GAP;
          end
        end else begin
          state_next = S_OVER;
        end
      end
      S_GAP: begin
        if (gap_done) state_next = S_ISSUE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // One-cycle round_start pulse, registered so it is glitch-free at the round block
  always_ff @(posedge clk) begin
    if (rst) round_start_q <= 1'b0;
    else     round_start_q <= fire;
  end

  // Ack-timeout and inter-round gap counters, zeroed on every state change
  always_ff @(posedge clk) begin
    if (rst || state_entry) begin
      ack_cnt <= 8'd0;
      gap_cnt <= 27'd0;
    end else begin
      if (state == S_WAIT_ACK) ack_cnt <= ack_cnt + 8'd1;
      if (state == S_GAP)      gap_cnt <= gap_cnt + 27'd1;
    end
  end

  // Game progress: level, score, round hit tally and end-of-game flags
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q    <= 3'd0;
      score_q    <= '0;
      round_hits <= 3'd0;
      game_won_q <= 1'b0;
      error_q    <= 1'b0;
    end else if (start_game) begin
      level_q    <= 3'd0;
      score_q    <= '0;
      round_hits <= 3'd0;
      game_won_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (count_hit) begin
        round_hits <= sat_hits(round_hits);
        score_q    <= sat_score(score_q);
      end
      if (eval_done) round_hits <= 3'd0;
      if (advance)   level_q    <= level_q + 3'd1;
      if (win)       game_won_q <= 1'b1;
      if (ack_fail)  error_q    <= 1'b1;
    end
  end

  // Round configuration: changes only between rounds (on level advance or a
  // fresh game), so it is stable whenever the round block samples it
  always_ff @(posedge clk) begin
    if (rst || start_game) begin
      interval_q <= cfg_interval(3'd0);
      duration_q <= cfg_duration(3'd0);
      molenum_q  <= cfg_molenum(3'd0);
    end else if (advance) begin
      interval_q <= cfg_interval(level_q + 3'd1);
      duration_q <= cfg_duration(level_q + 3'd1);
      molenum_q  <= cfg_molenum(level_q + 3'd1);
    end
  end

  assign round_start = round_start_q;
  assign interval    = interval_q;
  assign duration    = duration_q;
  assign molenum     = molenum_q;
  assign level       = level_q;
  assign score       = score_q;
  assign game_won    = game_won_q;
  assign error       = error_q;
  assign playing     = (state == S_ISSUE) || (state == S_WAIT_ACK) || (state == S_RUN) ||
                       (state == S_EVAL)  || (state == S_GAP);

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: drives two game_ctrl instances (8-bit and 2-bit score) in
// lockstep with a simple round-block model; every round_start is checked
// against expectations queued when the corresponding stimulus is issued.
module tb_game_ctrl;

  localparam logic [26:0] BI     = 27'd1000;
  localparam logic [26:0] BD     = 27'd640;
  localparam int          BM     = 5;
  localparam int          NL     = 4;
  localparam int          PH     = 2;
  localparam int          GAP_C  = 5;
  localparam int          ACK_TO = 15;

  logic clk = 1'b0;
  logic rst, start, round_over, hit_success;

  logic        round_start, playing, game_won, error;
  logic [26:0] interval, duration;
  logic [2:0]  molenum, level;
  logic [7:0]  score;

  logic        round_start_s, playing_s, game_won_s, error_s;
  logic [26:0] interval_s, duration_s;
  logic [2:0]  molenum_s, level_s;
  logic [1:0]  score_s;

  always #5 clk = ~clk;

  game_ctrl #(
    .NUM_LEVELS(NL), .BASE_INTERVAL(BI), .BASE_DURATION(BD), .BASE_MOLES(BM),
    .PASS_HITS(PH), .GAP_CYCLES(27'(GAP_C)), .ACK_TIMEOUT(ACK_TO), .SCORE_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .round_over(round_over),
    .hit_success(hit_success), .round_start(round_start), .interval(interval),
    .duration(duration), .molenum(molenum), .level(level), .score(score),
    .playing(playing), .game_won(game_won), .error(error)
  );

  game_ctrl #(
    .NUM_LEVELS(NL), .BASE_INTERVAL(BI), .BASE_DURATION(BD), .BASE_MOLES(BM),
    .PASS_HITS(PH), .GAP_CYCLES(27'(GAP_C)), .ACK_TIMEOUT(ACK_TO), .SCORE_W(2)
  ) dut_s (
    .clk(clk), .rst(rst), .start(start), .round_over(round_over),
    .hit_success(hit_success), .round_start(round_start_s), .interval(interval_s),
    .duration(duration_s), .molenum(molenum_s), .level(level_s), .score(score_s),
    .playing(playing_s), .game_won(game_won_s), .error(error_s)
  );

  typedef struct {
    int lvl;
    int sc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_lvl, m_sc;
  bit   m_over, m_won;
  logic rs_prev = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int exp_moles(input int lvl);
    return (BM + lvl > 7) ? 7 : BM + lvl;
  endfunction

  function automatic int min3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Each round_start is matched against the oldest queued expectation
  always @(negedge clk) begin
    if (round_start && rs_prev) check_val("rs_back_to_back", 32'(round_start), 0);
    if (round_start) begin
      if (sb_q.size() == 0) begin
        check_val("rs_unexpected", 32'(round_start), 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("pulse_interval", 32'(interval), 32'(BI >> mon_e.lvl));
        check_val("pulse_duration", 32'(duration), 32'(BD >> mon_e.lvl));
        check_val("pulse_molenum",  32'(molenum),  32'(exp_moles(mon_e.lvl)));
        check_val("pulse_level",    32'(level),    32'(mon_e.lvl));
        check_val("pulse_score",    32'(score),    32'(mon_e.sc));
        check_val("pulse_score_s",  32'(score_s),  32'(min3(mon_e.sc)));
        check_val("pulse_sync_s",   32'(round_start_s), 1);
        check_val("pulse_ro_high",  32'(round_over), 1);
      end
    end
    rs_prev <= round_start;
  end

  task automatic expect_round();
    sb_q.push_back('{lvl: m_lvl, sc: m_sc});
  endtask

  task automatic new_game_model();
    m_lvl  = 0;
    m_sc   = 0;
    m_over = 1'b0;
    m_won  = 1'b0;
  endtask

  task automatic wait_pulse(output int cyc);
    cyc = 0;
    while (!round_start && cyc < 60) begin
      tick(1);
      cyc++;
    end
    check_val("pulse_seen", 32'(round_start), 1);
  endtask

  task automatic check_reset(input string pfx);
    check_val({pfx, "_level"},    32'(level), 0);
    check_val({pfx, "_score"},    32'(score), 0);
    check_val({pfx, "_playing"},  32'(playing), 0);
    check_val({pfx, "_won"},      32'(game_won), 0);
    check_val({pfx, "_error"},    32'(error), 0);
    check_val({pfx, "_rstart"},   32'(round_start), 0);
    check_val({pfx, "_interval"}, 32'(interval), 32'(BI));
    check_val({pfx, "_duration"}, 32'(duration), 32'(BD));
    check_val({pfx, "_molenum"},  32'(molenum), BM);
  endtask

  // Called at the negedge where round_start is seen; acts as the round block
  task automatic play_round(input int hits, input bit poke_start);
    tick(1);
    round_over = 1'b0;
    tick(1);
    if (poke_start) begin
      start = 1'b1;
      tick(1);
      start = 1'b0;
    end
    for (int i = 0; i < hits - 1; i++) begin
      hit_success = 1'b1;
      tick(1);
      hit_success = 1'b0;
      tick(1);
    end
    hit_success = (hits > 0);
    round_over  = 1'b1;
    tick(1);
    hit_success = 1'b0;
    tick(1);
    m_sc = (m_sc + hits > 255) ? 255 : m_sc + hits;
    if (hits >= PH) begin
      if (m_lvl == NL - 1) begin
        m_won  = 1'b1;
        m_over = 1'b1;
      end else begin
        m_lvl++;
      end
    end else begin
      m_over = 1'b1;
    end
    check_val("round_level",   32'(level), 32'(m_lvl));
    check_val("round_score",   32'(score), 32'(m_sc));
    check_val("round_score_s", 32'(score_s), 32'(min3(m_sc)));
    check_val("round_playing", 32'(playing), 32'(!m_over));
    check_val("round_won",     32'(game_won), 32'(m_won));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int k;
    int h4[4];
    h4 = '{2, 2, 2, 3};

    rst = 1'b1; start = 1'b0; round_over = 1'b1; hit_success = 1'b0;
    new_game_model();
    tick(3);
    check_reset("rst");
    rst = 1'b0;
    tick(1);
    hit_success = 1'b1;
    tick(1);
    hit_success = 1'b0;
    tick(1);
    check_val("idle_hit_score", 32'(score), 0);
    check_val("idle_playing",   32'(playing), 0);

    // first round: pulse two cycles after start, level-0 config
    expect_round();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_val("t1_no_early_pulse", 32'(round_start), 0);
    check_val("t1_playing",        32'(playing), 1);
    tick(1);
    check_val("t1_pulse_latency",  32'(round_start), 1);

    // three hits, last one coinciding with round_over rising
    play_round(3, 1'b0);
    check_val("t2_interval_l1", 32'(interval), 32'(BI >> 1));
    check_val("t2_molenum_l1",  32'(molenum), BM + 1);
    tick(1);
    hit_success = 1'b1;
    tick(1);
    hit_success = 1'b0;
    expect_round();
    wait_pulse(cyc);
    check_val("t2_gap_length", 32'(cyc + 2), 32'(GAP_C + 1));

    // one hit fails the round; start inside RUN is ignored
    play_round(1, 1'b1);
    tick(2);
    check_val("t3_hold_score", 32'(score), 32'(m_sc));
    check_val("t3_hold_level", 32'(level), 32'(m_lvl));
    new_game_model();
    expect_round();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_val("t3_restart_score", 32'(score), 0);
    check_val("t3_restart_level", 32'(level), 0);
    check_val("t3_restart_intv",  32'(interval), 32'(BI));
    wait_pulse(cyc);

    // clear all levels; 2-bit score saturates
    for (int i = 0; i < NL; i++) begin
      if (i > 0) begin
        expect_round();
        wait_pulse(cyc);
      end
      play_round(h4[i], 1'b0);
    end
    check_val("t4_won",         32'(game_won), 1);
    check_val("t4_level",       32'(level), NL - 1);
    check_val("t4_score_sat_s", 32'(score_s), 3);
    check_val("t4_molenum_cap", 32'(molenum), 7);

    // round block never acknowledges
    new_game_model();
    expect_round();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_val("t5_won_cleared", 32'(game_won), 0);
    wait_pulse(cyc);
    tick(14);
    check_val("t5_no_early_error", 32'(error), 0);
    k = 0;
    while (!error && k < 6) begin
      tick(1);
      k++;
    end
    check_val("t5_error",   32'(error), 1);
    check_val("t5_playing", 32'(playing), 0);
    expect_round();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_val("t5_error_cleared", 32'(error), 0);
    check_val("t5_replaying",     32'(playing), 1);
    wait_pulse(cyc);

    // reset in the middle of a round
    tick(1);
    round_over = 1'b0;
    tick(1);
    hit_success = 1'b1;
    tick(1);
    hit_success = 1'b0;
    check_val("t6_run_score", 32'(score), 1);
    rst = 1'b1;
    tick(1);
    check_reset("t6");
    rst = 1'b0;
    round_over = 1'b1;
    tick(3);
    check_val("t6_stays_idle", 32'(playing), 0);
    check_val("sb_drained", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
